imuldiv_muldiv_dispatch: RTL and testbench
==========================================

IMULDIV_MULDIV_DISPATCH -- requirements
Module: imuldiv_MulDivDispatch

Interface
REQ-001 Parameters: none; the block SHALL have no parameters, and all widths SHALL be fixed as listed.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 muldivreq_msg_fn  input  3  op code: 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU, 5-7 illegal.
REQ-005 muldivreq_msg_a / muldivreq_msg_b  input  32 each  operands A and B.
REQ-006 muldivreq_val  input  1 / muldivreq_rdy  output  1  upstream request handshake.
REQ-007 muldivresp_msg_result  output  64  response payload.
REQ-008 muldivresp_val  output  1 / muldivresp_rdy  input  1  upstream response handshake.
REQ-009 mulreq_msg_a / mulreq_msg_b  output  32 each; mulreq_val  output  1; mulreq_rdy  input  1  multiplier request port.
REQ-010 mulresp_msg_result  input  64; mulresp_val  input  1; mulresp_rdy  output  1  multiplier response port.
REQ-011 divreq_msg_fn  output  1; divreq_msg_a / divreq_msg_b  output  32 each; divreq_val  output  1; divreq_rdy  input  1  divider request port.
REQ-012 divresp_msg_result  input  64 ({remainder, quotient}); divresp_val  input  1; divresp_rdy  output  1  divider response port.

Function
REQ-013 The block SHALL hold exactly one operation in flight, using FSM states IDLE, MUL_REQ, DIV_REQ, MUL_WAIT, DIV_WAIT and RESP.
REQ-014 In IDLE, muldivreq_rdy SHALL be 1; in every other state it SHALL be 0.
REQ-015 On muldivreq_val && muldivreq_rdy, the block SHALL register fn, a and b, then transition as follows:
- fn=0 -> MUL_REQ
- fn=1-4 -> DIV_REQ
- fn=5-7 -> RESP, with the result register loaded with 64'b0
REQ-016 In MUL_REQ, mulreq_val SHALL be 1 and mulreq_msg_a/b SHALL be driven from the registered operands.
- On mulreq_rdy the FSM SHALL move to MUL_WAIT.
- Otherwise the FSM SHALL stay in MUL_REQ with the payload stable.
REQ-017 In DIV_REQ, divreq_val SHALL be 1 and divreq_msg_a/b SHALL be driven from the registered operands.
- divreq_msg_fn SHALL be 0 (signed) for DIV/REM and 1 (unsigned) for DIVU/REMU.
- On divreq_rdy the FSM SHALL move to DIV_WAIT.
REQ-018 In MUL_WAIT, mulresp_rdy SHALL be 1.
- On mulresp_val the block SHALL capture mulresp_msg_result unchanged into the result register and move to RESP.
REQ-019 In DIV_WAIT, divresp_rdy SHALL be 1.
- On divresp_val the block SHALL capture divresp_msg_result unchanged into the result register and move to RESP.
REQ-020 mulresp_rdy / divresp_rdy SHALL be 0 in all states except their own WAIT state; a stray resp_val from the non-selected unit SHALL be ignored.
REQ-021 In RESP, muldivresp_val SHALL be 1 and muldivresp_msg_result SHALL be driven from the result register.
- The payload SHALL stay stable until muldivresp_rdy.
- On muldivresp_val && muldivresp_rdy the FSM SHALL return to IDLE.
REQ-022 mulreq_val, divreq_val and muldivresp_val SHALL never be asserted outside their named states.
REQ-023 Latency: a request accepted in cycle N SHALL present the sub-unit request in cycle N+1.
- A sub-unit response accepted in cycle M SHALL present muldivresp_val in cycle M+1.
- An illegal op SHALL present muldivresp_val in cycle N+1.
REQ-024 The next request SHALL be accepted no earlier than the cycle after the response handshake; the block SHALL NOT support back-to-back overlap.
REQ-025 Operand, fn and result registers SHALL load only in the cycles named above and SHALL hold otherwise.

Reset
REQ-026 While reset=1, the FSM SHALL enter IDLE.
REQ-027 All val outputs and mulresp_rdy/divresp_rdy SHALL be 0 during reset; muldivreq_rdy SHALL be 0 during reset and 1 in the first cycle after reset deasserts.
REQ-028 The result register SHALL clear to 64'b0 on reset.
REQ-029 Reset asserted mid-operation (any state) SHALL abandon the operation without producing a response; the sub-units share the same reset.

Verification
REQ-030 MUL: fn=0, a=7, b=0xFFFFFFFD, multiplier stub replies 0xFFFFFFFF_FFFFFFEB after 3 cycles -> muldivresp_msg_result=0xFFFFFFFF_FFFFFFEB, with muldivresp_val one cycle after mulresp handshake.
REQ-031 DIV: fn=1, a=0xFFFFFFF9 (-7), b=2 -> divreq_msg_fn=0; divider stub returns 0xFFFFFFFF_FFFFFFFD -> response passed through unchanged.
REQ-032 REMU with divreq_rdy held 0 for 4 cycles -> divreq_val stays 1 with a/b stable; divreq_msg_fn=1; muldivreq_rdy stays 0 throughout.
REQ-033 Backpressure: muldivresp_rdy=0 for 5 cycles in RESP -> val and result held; a second muldivreq_val is not accepted until after the handshake.
REQ-034 Illegal fn=3'd6 -> no sub-unit val asserted; result 64'b0 presented one cycle after acceptance.
REQ-035 Reset pulsed in DIV_WAIT, then a divresp_val pulse -> no muldivresp_val; muldivreq_rdy=1 the cycle after reset deasserts; the next MUL completes correctly.

Source files
------------

// File: rtl/imuldiv_muldiv_dispatch.sv
// imuldiv_muldiv_dispatch
//   Accepts one mul/div request at a time, forwards it to the multiplier or
//   divider sub-unit, and returns the sub-unit's 64-bit result unchanged.
//   Illegal op codes (5-7) are answered directly with a zero result.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   muldivreq_*                      upstream request  (fn, a, b, val/rdy)
//   muldivresp_*                     upstream response (result, val/rdy)
//   mulreq_* / mulresp_*             multiplier request/response ports
//   divreq_* / divresp_*             divider request/response ports
//
// Handshake outputs are flops loaded from the next-state decode, so each
// one is an exact registered image of the FSM state (forced low in reset).
module imuldiv_muldiv_dispatch (
  input  logic        clk,
  input  logic        reset,

  input  logic [2:0]  muldivreq_msg_fn,
  input  logic [31:0] muldivreq_msg_a,
  input  logic [31:0] muldivreq_msg_b,
  input  logic        muldivreq_val,
  output logic        muldivreq_rdy,

  output logic [63:0] muldivresp_msg_result,
  output logic        muldivresp_val,
  input  logic        muldivresp_rdy,

  output logic [31:0] mulreq_msg_a,
  output logic [31:0] mulreq_msg_b,
  output logic        mulreq_val,
  input  logic        mulreq_rdy,

  input  logic [63:0] mulresp_msg_result,
  input  logic        mulresp_val,
  output logic        mulresp_rdy,

  output logic        divreq_msg_fn,
  output logic [31:0] divreq_msg_a,
  output logic [31:0] divreq_msg_b,
  output logic        divreq_val,
  input  logic        divreq_rdy,

  input  logic [63:0] divresp_msg_result,
  input  logic        divresp_val,
  output logic        divresp_rdy
);

  localparam int unsigned OP_W  = 32;
  localparam int unsigned RES_W = 64;

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] MUL_REQ  = 3'd1;
  localparam logic [2:0] DIV_REQ  = 3'd2;
  localparam logic [2:0] MUL_WAIT = 3'd3;
  localparam logic [2:0] DIV_WAIT = 3'd4;
  localparam logic [2:0] RESP     = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [OP_W-1:0]  a_q;
  logic [OP_W-1:0]  b_q;
  logic             div_unsigned_q;
  logic [RES_W-1:0] result_q;

  logic req_fire_c;
  logic mulreq_fire_c;
  logic divreq_fire_c;
  logic mulresp_fire_c;
  logic divresp_fire_c;
  logic resp_fire_c;
  logic fn_illegal_c;

  assign req_fire_c     = muldivreq_val && muldivreq_rdy;
  assign mulreq_fire_c  = mulreq_val && mulreq_rdy;
  assign divreq_fire_c  = divreq_val && divreq_rdy;
  assign mulresp_fire_c = mulresp_val && mulresp_rdy;
  assign divresp_fire_c = divresp_val && divresp_rdy;
  assign resp_fire_c    = muldivresp_val && muldivresp_rdy;
  assign fn_illegal_c   = muldivreq_msg_fn > FN_REMU;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_fire_c) begin
          if (muldivreq_msg_fn == FN_MUL) state_next = MUL_REQ;
          else if (fn_illegal_c)          state_next = RESP;
          else                            state_next = DIV_REQ;
        end
      end
      MUL_REQ:  if (mulreq_fire_c)  state_next = MUL_WAIT;
      DIV_REQ:  if (divreq_fire_c)  state_next = DIV_WAIT;
      MUL_WAIT: if (mulresp_fire_c) state_next = RESP;
      DIV_WAIT: if (divresp_fire_c) state_next = RESP;
      RESP:     if (resp_fire_c)    state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Registered handshake outputs, one per state
  always_ff @(posedge clk) begin
    if (reset) begin
      muldivreq_rdy  <= 1'b0;
      mulreq_val     <= 1'b0;
      divreq_val     <= 1'b0;
      mulresp_rdy    <= 1'b0;
      divresp_rdy    <= 1'b0;
      muldivresp_val <= 1'b0;
    end else begin
      muldivreq_rdy  <= (state_next == IDLE);
      mulreq_val     <= (state_next == MUL_REQ);
      divreq_val     <= (state_next == DIV_REQ);
      mulresp_rdy    <= (state_next == MUL_WAIT);
      divresp_rdy    <= (state_next == DIV_WAIT);
      muldivresp_val <= (state_next == RESP);
    end
  end

  // Operand capture on acceptance; result capture on sub-unit response
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q            <= '0;
      b_q            <= '0;
      div_unsigned_q <= 1'b0;
      result_q       <= '0;
    end else begin
      if (req_fire_c) begin
        a_q            <= muldivreq_msg_a;
        b_q            <= muldivreq_msg_b;
        div_unsigned_q <= (muldivreq_msg_fn == FN_DIVU) ||
                          (muldivreq_msg_fn == FN_REMU);
        if (fn_illegal_c) result_q <= '0;
      end
      if (mulresp_fire_c) result_q <= mulresp_msg_result;
      if (divresp_fire_c) result_q <= divresp_msg_result;
    end
  end

  // Both sub-units see the same operand registers; only val differs
  assign mulreq_msg_a          = a_q;
  assign mulreq_msg_b          = b_q;
  assign divreq_msg_a          = a_q;
  assign divreq_msg_b          = b_q;
  assign divreq_msg_fn         = div_unsigned_q;
  assign muldivresp_msg_result = result_q;

  // FN_REM kept for readability of the op map; signed ops are the default
  logic unused_c;
  assign unused_c = ^{FN_REM, RES_W[0]};

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// Testbench for imuldiv_muldiv_dispatch: the bench plays the upstream client
// and both sub-unit stubs; expected results come from plain arithmetic.
module tb_imuldiv_muldiv_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
  logic        muldivreq_val, muldivreq_rdy;
  logic [63:0] muldivresp_msg_result;
  logic        muldivresp_val, muldivresp_rdy;
  logic [31:0] mulreq_msg_a, mulreq_msg_b;
  logic        mulreq_val, mulreq_rdy;
  logic [63:0] mulresp_msg_result;
  logic        mulresp_val, mulresp_rdy;
  logic        divreq_msg_fn;
  logic [31:0] divreq_msg_a, divreq_msg_b;
  logic        divreq_val, divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic        divresp_val, divresp_rdy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imuldiv_muldiv_dispatch dut (
    .clk(clk), .reset(reset),
    .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
    .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val),
    .muldivreq_rdy(muldivreq_rdy),
    .muldivresp_msg_result(muldivresp_msg_result),
    .muldivresp_val(muldivresp_val), .muldivresp_rdy(muldivresp_rdy),
    .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b),
    .mulreq_val(mulreq_val), .mulreq_rdy(mulreq_rdy),
    .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val),
    .mulresp_rdy(mulresp_rdy),
    .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a),
    .divreq_msg_b(divreq_msg_b), .divreq_val(divreq_val),
    .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val),
    .divresp_rdy(divresp_rdy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Signed or unsigned 32-bit division packed as {remainder, quotient}
  function automatic logic [63:0] div_pair(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (sgn) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 64'(pa * pb);
  endfunction

  // Reference: what the upstream client must get back for (fn, a, b)
  function automatic logic [63:0] model(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    case (fn)
      3'd0:       return smul(a, b);
      3'd1, 3'd3: return div_pair(1'b1, a, b);
      3'd2, 3'd4: return div_pair(1'b0, a, b);
      default:    return 64'd0;
    endcase
  endfunction

  task automatic idle_inputs();
    muldivreq_val = 1'b0; muldivresp_rdy = 1'b0;
    mulreq_rdy = 1'b0; divreq_rdy = 1'b0;
    mulresp_val = 1'b0; divresp_val = 1'b0;
    mulresp_msg_result = {$urandom, $urandom};
    divresp_msg_result = {$urandom, $urandom};
  endtask

  // One full transaction with configurable stalls on every handshake
  task automatic run_txn(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input int req_stall, input int resp_delay, input int out_stall);
    logic [63:0] exp, stub_res;
    logic        is_mul, legal, cfn;
    logic [31:0] ca, cb;
    exp    = model(fn, a, b);
    legal  = (fn <= 3'd4);
    is_mul = (fn == 3'd0);
    ca = '0; cb = '0; cfn = 1'b0;
    @(negedge clk);
    chk("req_rdy_idle", 64'(muldivreq_rdy), 64'd1);
    muldivreq_val = 1'b1; muldivreq_msg_fn = fn;
    muldivreq_msg_a = a; muldivreq_msg_b = b;
    @(negedge clk);
    muldivreq_val = 1'b0;
    muldivreq_msg_a = $urandom; muldivreq_msg_b = $urandom;
    chk("req_rdy_busy", 64'(muldivreq_rdy), 64'd0);
    if (!legal) begin
      chk("illegal_mulreq_val", 64'(mulreq_val), 64'd0);
      chk("illegal_divreq_val", 64'(divreq_val), 64'd0);
    end else begin
      for (int i = 0; i <= req_stall; i++) begin
        chk("sub_req_val", 64'(is_mul ? mulreq_val : divreq_val), 64'd1);
        chk("other_req_val", 64'(is_mul ? divreq_val : mulreq_val), 64'd0);
        chk("sub_req_a", 64'(is_mul ? mulreq_msg_a : divreq_msg_a), 64'(a));
        chk("sub_req_b", 64'(is_mul ? mulreq_msg_b : divreq_msg_b), 64'(b));
        if (!is_mul) chk("div_fn", 64'(divreq_msg_fn), 64'((fn == 3'd2) || (fn == 3'd4)));
        chk("req_rdy_stall", 64'(muldivreq_rdy), 64'd0);
        chk("resp_val_early", 64'(muldivresp_val), 64'd0);
        if (i == req_stall) begin
          ca  = is_mul ? mulreq_msg_a : divreq_msg_a;
          cb  = is_mul ? mulreq_msg_b : divreq_msg_b;
          cfn = divreq_msg_fn;
          if (is_mul) mulreq_rdy = 1'b1; else divreq_rdy = 1'b1;
        end
        @(negedge clk);
      end
      mulreq_rdy = 1'b0; divreq_rdy = 1'b0;
      stub_res = is_mul ? smul(ca, cb) : div_pair(~cfn, ca, cb);
      for (int i = 0; i <= resp_delay; i++) begin
        chk("sub_req_val_drop", 64'(mulreq_val | divreq_val), 64'd0);
        chk("own_resp_rdy", 64'(is_mul ? mulresp_rdy : divresp_rdy), 64'd1);
        chk("other_resp_rdy", 64'(is_mul ? divresp_rdy : mulresp_rdy), 64'd0);
        chk("resp_val_wait", 64'(muldivresp_val), 64'd0);
        // Stray response from the unit not in use must be ignored
        if (is_mul) begin divresp_val = 1'b1; divresp_msg_result = {$urandom, $urandom}; end
        else        begin mulresp_val = 1'b1; mulresp_msg_result = {$urandom, $urandom}; end
        if (i == resp_delay) begin
          if (is_mul) begin mulresp_val = 1'b1; mulresp_msg_result = stub_res; end
          else        begin divresp_val = 1'b1; divresp_msg_result = stub_res; end
        end
        @(negedge clk);
      end
      idle_inputs();
    end
    for (int i = 0; i <= out_stall; i++) begin
      chk("resp_val", 64'(muldivresp_val), 64'd1);
      chk("resp_result", muldivresp_msg_result, exp);
      chk("sub_vals_in_resp", 64'(mulreq_val | divreq_val), 64'd0);
      chk("req_rdy_resp", 64'(muldivreq_rdy), 64'd0);
      if (i < out_stall) begin
        muldivreq_val = 1'b1; muldivreq_msg_fn = 3'd0;
      end else begin
        muldivreq_val = 1'b0; muldivresp_rdy = 1'b1;
      end
      @(negedge clk);
    end
    muldivresp_rdy = 1'b0;
    chk("resp_val_done", 64'(muldivresp_val), 64'd0);
    chk("req_rdy_back", 64'(muldivreq_rdy), 64'd1);
  endtask

  initial begin
    logic [2:0]  fn;
    logic [31:0] a, b;
    reset = 1'b1;
    muldivreq_msg_fn = '0; muldivreq_msg_a = '0; muldivreq_msg_b = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_req_rdy", 64'(muldivreq_rdy), 64'd0);
    chk("rst_vals", 64'({mulreq_val, divreq_val, muldivresp_val}), 64'd0);
    chk("rst_resp_rdys", 64'({mulresp_rdy, divresp_rdy}), 64'd0);
    chk("rst_result", muldivresp_msg_result, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req_rdy", 64'(muldivreq_rdy), 64'd1);

    // Directed cases
    run_txn(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 3, 0);
    chk("mul_example_const", muldivresp_msg_result, 64'hFFFF_FFFF_FFFF_FFEB);
    run_txn(3'd1, 32'hFFFF_FFF9, 32'd2, 0, 1, 0);
    run_txn(3'd4, 32'd100, 32'd7, 4, 0, 0);
    run_txn(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 2, 5);
    run_txn(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0);
    run_txn(3'd3, 32'hFFFF_FFF9, 32'd2, 1, 0, 2);

    // Reset while waiting on the divider
    @(negedge clk);
    muldivreq_val = 1'b1; muldivreq_msg_fn = 3'd1;
    muldivreq_msg_a = 32'd50; muldivreq_msg_b = 32'd5;
    @(negedge clk);
    muldivreq_val = 1'b0; divreq_rdy = 1'b1;
    @(negedge clk);
    divreq_rdy = 1'b0;
    chk("divwait_rdy", 64'(divresp_rdy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_vals", 64'({mulreq_val, divreq_val, muldivresp_val}), 64'd0);
    chk("midrst_rdys", 64'({muldivreq_rdy, mulresp_rdy, divresp_rdy}), 64'd0);
    reset = 1'b0;
    divresp_val = 1'b1; divresp_msg_result = 64'hDEAD_BEEF_0000_000A;
    @(negedge clk);
    divresp_val = 1'b0;
    chk("postrst_req_rdy", 64'(muldivreq_rdy), 64'd1);
    chk("postrst_no_resp", 64'(muldivresp_val), 64'd0);
    chk("postrst_divresp_rdy", 64'(divresp_rdy), 64'd0);
    @(negedge clk);
    chk("postrst_no_resp2", 64'(muldivresp_val), 64'd0);
    run_txn(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2, 1);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      fn = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (t % 4 == 0) b = 32'($urandom_range(1, 9));
      if (b == 32'd0) b = 32'd1;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      run_txn(fn, a, b, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
